fifo_wr_ptr_ctrl: RTL
=====================

Name: fifo_wr_ptr_ctrl

Overview:
Write-side pointer controller for the asynchronous FIFO, running entirely in the write clock domain.
- Maintains the binary and Gray write pointers and produces the RAM write address.
- Synchronises the read-domain Gray pointer through a flop chain and converts it to binary for level computation.
- Generates full, almostFull and a sticky overflow flag.
- Its wrPtrGray output is the pointer the read side synchronises and converts back to binary.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth DEPTH = 2^ADDR_W; pointers are ADDR_W+1 bits wide.
SYNC_STAGES, 2, number of synchroniser flops on rdPtrGrayAsync; legal range 2..4.
AF_MARGIN, 2, almostFull asserts when free slots <= AF_MARGIN; legal range 1..DEPTH-1.

Ports:
clk  in  1  write-domain clock, rising edge.
rstN  in  1  asynchronous active-low reset; assertion is immediate, deassertion is synchronised externally.
wrEn  in  1  push request from the producer.
rdPtrGrayAsync  in  ADDR_W+1  read-domain Gray pointer, asynchronous to clk.
wrAccept  out  1  combinational, equal to wrEn & ~full; qualifies the RAM write.
wrAddr  out  ADDR_W  RAM write address, equal to wrBin[ADDR_W-1:0].
wrPtrGray  out  ADDR_W+1  registered Gray write pointer sent to the read domain.
full  out  1  registered FIFO-full flag.
almostFull  out  1  registered flag, asserted when level >= DEPTH-AF_MARGIN.
level  out  ADDR_W+1  registered occupancy as seen from the write domain, range 0..DEPTH.
overflow  out  1  sticky error flag.

Behaviour:
- Reset (rstN=0, asynchronous):
  - wrBin, wrPtrGray, all sync flops, full, almostFull, level and overflow go to 0.
  - wrAddr=0; wrAccept follows wrEn.
- Push rule: push = wrEn & ~full.
  - On a push edge, wrBin <= wrBin+1, wrapping modulo 2^(ADDR_W+1).
  - On a push edge, wrPtrGray <= (wrBin+1) ^ ((wrBin+1)>>1).
  - With no push, both pointers hold.
- wrPtrGray is driven directly from a flop, never through combinational logic, and changes by exactly one bit per push.
- Synchroniser:
  - rdPtrGrayAsync passes through SYNC_STAGES flops to give rqSync.
  - A stable input appears on rqSync after SYNC_STAGES edges.
  - No logic sits between the sync flops.
- Gray-to-binary: rdBinSync[i] = XOR of rqSync[ADDR_W:i], computed combinationally from rqSync.
- Next-state terms:
  - wrBinNext = wrBin + push.
  - wrGrayNext = Gray of wrBinNext.
- full <= (wrGrayNext == {~rqSync[ADDR_W:ADDR_W-1], rqSync[ADDR_W-2:0]}).
  - full asserts on the same edge as the DEPTH-th outstanding push.
  - full deasserts SYNC_STAGES+1 edges after the read pointer advances.
- level <= (wrBinNext - rdBinSync) mod 2^(ADDR_W+1).
  - This is pessimistic: it never under-reports occupancy.
- almostFull <= (level computed from wrBinNext) >= DEPTH-AF_MARGIN, registered in the same cycle as level.
- overflow:
  - Sets on any edge where wrEn=1 and full=1.
  - Cleared only by reset.
  - The rejected write changes no pointer.
- Simultaneous events:
  - A push and a read-pointer update in the same cycle are both reflected in the next full and level.
  - The flags are consistent with each other: full=1 implies level=DEPTH and almostFull=1.
- Wrap-around: wrBin wraps from 2^(ADDR_W+1)-1 to 0 and wrPtrGray from 2^ADDR_W to 0, with no glitch and no effect on the flags.
- Reset mid-operation:
  - Outputs return to their reset values immediately, independent of clk.
  - A pending push in that cycle is lost.
  - The read domain must be reset in the same reset event.

Test Plan:
1. Reset with ADDR_W=4, wrEn toggling -> during and after reset: wrPtrGray=0x00, wrAddr=0, full=0, level=0, overflow=0.
2. rdPtrGrayAsync=0, 16 consecutive pushes ->
   - wrPtrGray steps 0x01,0x03,0x02,0x06,...
   - After the 16th push: wrPtrGray=0x18, wrAddr=0, level=16, full=1.
   - almostFull first asserts after the 14th push.
3. While full, wrEn=1 for 3 cycles -> wrAccept=0, pointers unchanged, overflow=1 and stays 1 after wrEn drops.
4. From full, set rdPtrGrayAsync=0x06 (binary 4) ->
   - full=0 and level=12 exactly 3 edges later (SYNC_STAGES=2).
   - almostFull=0.
5. Run 40 pushes while the read pointer tracks 2 entries behind -> wrBin wraps 31->0, wrPtrGray 0x10->0x00, full never asserts, level stays within 2..4.
6. Assert rstN mid-burst, asynchronously between clock edges -> all outputs read 0 before the next edge; after release the first push gives wrPtrGray=0x01.

Source files
------------

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller of an asynchronous FIFO: binary/Gray write pointers,
// read-pointer synchroniser, and full / almostFull / level / sticky overflow flags.
module fifo_wr_ptr_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              wrEn,
  input  logic [ADDR_W:0]   rdPtrGrayAsync,
  output logic              wrAccept,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [ADDR_W:0]   wrPtrGray,
  output logic              full,
  output logic              almostFull,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);
  localparam logic [PW-1:0] FULL_FLIP = PW'(3) << (ADDR_W - 1);

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq_sync;
  logic [PW-1:0] rd_bin_sync;
  logic          push;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          almost_full_next;

  // Handshake: wrEn is the producer's request, wrAccept its same-cycle acceptance.
  // A word is written exactly on a rising edge where wrAccept=1; wrEn while full is dropped.
  assign push     = wrEn & ~full;
  assign wrAccept = push;
  assign wrAddr   = wr_bin[ADDR_W-1:0];

  // Plain flop chain: nothing combinational between stages.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rdPtrGrayAsync;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i < PW; i++) rd_bin_sync[i] = ^(rq_sync >> i);
  end

  always_comb begin
    wr_bin_next      = wr_bin + PW'(push);
    wr_gray_next     = wr_bin_next ^ (wr_bin_next >> 1);
    // Full when the write pointer is one lap ahead: top two Gray bits differ, rest equal.
    full_next        = (wr_gray_next == (rq_sync ^ FULL_FLIP));
    level_next       = wr_bin_next - rd_bin_sync;
    almost_full_next = (level_next >= AF_THRESH);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_bin     <= '0;
      wrPtrGray  <= '0;
      full       <= 1'b0;
      almostFull <= 1'b0;
      level      <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_bin     <= wr_bin_next;
      wrPtrGray  <= wr_gray_next;
      full       <= full_next;
      almostFull <= almost_full_next;
      level      <= level_next;
      if (wrEn && full) overflow <= 1'b1;
    end
  end

endmodule
